rv32i_decoder: RTL and testbench
================================

Name: rv32i_decoder

Overview:
- Combinational RV32I base-ISA instruction decoder inside the ID stage.
- Takes the fetched instruction word and its PC, and produces one core::pipeline_bus_t record.
- The ID stage registers that record, and forces it to a bubble on flush.
- clk/rst are used only by the optional statistics counter.

Parameters:
- XLEN, 32, datapath width. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-low reset.
- instruction_i  input  32  raw instruction word.
- pc_i  input  32  PC of instruction_i.
- id_bus_o  output  core::pipeline_bus_t  decoded record. Fields:
  - pc[31:0], instr[31:0]
  - format (R,I,S,B,U,J,NOP)
  - rd[4:0], rs1[4:0], rs2[4:0]
  - imm[31:0]
  - alu_op (ALU_ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,LUI,NOP)
  - mem_op (MEM_LB,LH,LW,LBU,LHU,SB,SH,SW,NOP)
  - rd_we, use_pc (ALU operand A = pc), is_branch, is_jump, illegal

Behaviour:
- Fully combinational: instruction_i/pc_i to id_bus_o, zero cycles, no handshake. Output is independent of rst.
- pc = pc_i; instr = instruction_i.
- Register fields are always extracted: rd=[11:7], rs1=[19:15], rs2=[24:20].
- Immediate by format, all sign-extended from bit 31:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R and NOP: imm=0.
- Opcode decode:
  - 0110011 OP: format R, rd_we=1. ALU op from funct3/funct7: funct7=0100000 selects SUB (f3=000) or SRA (f3=101); funct7=0000000 selects normal ops; any other funct7 is illegal.
  - 0010011 OP-IMM: format I, rd_we=1.
    - SLLI requires funct7=0000000.
    - SRLI/SRAI are chosen by funct7 (0000000 / 0100000); anything else is illegal.
  - 0000011 LOAD: format I, ALU_ADD, rd_we=1. mem_op from f3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal.
  - 0100011 STORE: format S, ALU_ADD, rd_we=0. mem_op from f3: 000 SB, 001 SH, 010 SW; others illegal.
  - 1100011 BRANCH: format B, is_branch=1, ALU_SUB, rd_we=0. f3 in {000,001,100,101,110,111}; others illegal.
  - 0110111 LUI: format U, ALU_LUI, rd_we=1.
  - 0010111 AUIPC: format U, ALU_ADD, use_pc=1, rd_we=1.
  - 1101111 JAL: format J, is_jump=1, use_pc=1, ALU_ADD, rd_we=1.
  - 1100111 JALR: format I, is_jump=1, ALU_ADD, rd_we=1. f3 other than 000 is illegal.
  - Any other opcode, or instr[1:0]!=11: illegal.
- Illegal instruction: illegal=1, format NOP, ALU_NOP, MEM_NOP, rd_we=0, is_branch=0, is_jump=0. Register fields are still extracted.
- Bubble: instruction_i equal to 0x00000000 or riscv::I_NOP (0x00000013) decodes as follows:
  - format NOP, ALU_NOP, MEM_NOP
  - rd_we=0, illegal=0, imm=0
- rd=x0 on a writing instruction: rd_we stays 1; the register file ignores writes to x0.
- FENCE/SYSTEM (0001111/1110011) are out of scope and decode as illegal.

Optional Feature:
- ILLEGAL_CNT_EN defined:
  - Adds output illegal_cnt_o [31:0].
  - Increments on each posedge clk where illegal=1.
  - Reset asynchronously to 0 when rst=0.
  - Wraps from 0xFFFFFFFF to 0.
- Not defined: no counter, no port; clk/rst unused.

Test Plan:
- 0x002081B3 (add x3,x1,x2) -> format R, rd=3, rs1=1, rs2=2, ALU_ADD, MEM_NOP, rd_we=1, illegal=0.
- 0xFFC12283 (lw x5,-4(x2)) -> format I, imm=0xFFFFFFFC, MEM_LW, ALU_ADD, rd=5, rd_we=1.
- 0x0060A423 (sw x6,8(x1)) -> format S, imm=0x00000008, MEM_SW, rs1=1, rs2=6, rd_we=0.
- 0xFE208CE3 (beq x1,x2,-8) -> format B, imm=0xFFFFFFF8, is_branch=1, ALU_SUB, rd_we=0.
- 0x123453B7 (lui x7,0x12345) -> format U, imm=0x12345000, ALU_LUI, rd=7, rd_we=1.
- 0x00000013 and 0x00000000 -> bubble, illegal=0.
- 0xFFFFFFFF -> illegal=1, rd_we=0. With ILLEGAL_CNT_EN: three such cycles give illegal_cnt_o=3; rst low clears it to 0 immediately.

Source files
------------

// File: rtl/rv32i_decoder.sv
// RV32I base-ISA instruction decoder for the ID stage, with the shared riscv/core packages.
// Define ILLEGAL_CNT_EN to add illegal_cnt_o, a wrapping count of cycles that decode as illegal.

package riscv;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // addi x0, x0, 0
    localparam logic [31:0] I_NOP = 32'h0000_0013;
endpackage

package core;
    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NOP
    } format_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_NOP
    } alu_op_t;

    typedef enum logic [3:0] {
        MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
        MEM_SB, MEM_SH, MEM_SW, MEM_NOP
    } mem_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        format_t     format;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        alu_op_t     alu_op;
        mem_op_t     mem_op;
        logic        rd_we;
        logic        use_pc;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } pipeline_bus_t;
endpackage

module rv32i_decoder #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    instruction_i,
    input  logic [XLEN-1:0]    pc_i,
    output core::pipeline_bus_t id_bus_o
`ifdef ILLEGAL_CNT_EN
    ,
    output logic [31:0]        illegal_cnt_o
`endif
);
    import core::*;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        bubble;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    format_t     fmt;
    alu_op_t     alu;
    mem_op_t     mem;
    logic        we;
    logic        upc;
    logic        br;
    logic        jmp;
    logic        bad;

    assign opcode = instruction_i[6:0];
    assign funct3 = instruction_i[14:12];
    assign funct7 = instruction_i[31:25];
    assign bubble = (instruction_i == 32'h0000_0000) || (instruction_i == riscv::I_NOP);

    assign imm_i = {{20{instruction_i[31]}}, instruction_i[31:20]};
    assign imm_s = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
    assign imm_b = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                    instruction_i[30:25], instruction_i[11:8], 1'b0};
    assign imm_u = {instruction_i[31:12], 12'b0};
    assign imm_j = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                    instruction_i[20], instruction_i[30:21], 1'b0};

    // funct3 -> ALU op for the base (funct7 = 0) OP/OP-IMM encodings
    function automatic alu_op_t base_alu(input logic [2:0] f3);
        alu_op_t op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        fmt = FMT_NOP;
        alu = ALU_NOP;
        mem = MEM_NOP;
        we  = 1'b0;
        upc = 1'b0;
        br  = 1'b0;
        jmp = 1'b0;
        bad = 1'b0;

        if (!bubble) begin
            if (instruction_i[1:0] != 2'b11) begin
                bad = 1'b1;
            end else begin
                case (opcode)
                    riscv::OPC_OP: begin
                        fmt = FMT_R;
                        we  = 1'b1;
                        if (funct7 == riscv::F7_BASE) begin
                            alu = base_alu(funct3);
                        end else if (funct7 == riscv::F7_ALT && funct3 == 3'b000) begin
                            alu = ALU_SUB;
                        end else if (funct7 == riscv::F7_ALT && funct3 == 3'b101) begin
                            alu = ALU_SRA;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    riscv::OPC_OP_IMM: begin
                        fmt = FMT_I;
                        we  = 1'b1;
                        alu = base_alu(funct3);
                        // shift-immediates reuse imm[11:5] as funct7
                        if (funct3 == 3'b001 && funct7 != riscv::F7_BASE) begin
                            bad = 1'b1;
                        end else if (funct3 == 3'b101) begin
                            if (funct7 == riscv::F7_ALT) begin
                                alu = ALU_SRA;
                            end else if (funct7 != riscv::F7_BASE) begin
                                bad = 1'b1;
                            end
                        end
                    end
                    riscv::OPC_LOAD: begin
                        fmt = FMT_I;
                        alu = ALU_ADD;
                        we  = 1'b1;
                        case (funct3)
                            3'b000:  mem = MEM_LB;
                            3'b001:  mem = MEM_LH;
                            3'b010:  mem = MEM_LW;
                            3'b100:  mem = MEM_LBU;
                            3'b101:  mem = MEM_LHU;
                            default: bad = 1'b1;
                        endcase
                    end
                    riscv::OPC_STORE: begin
                        fmt = FMT_S;
                        alu = ALU_ADD;
                        case (funct3)
                            3'b000:  mem = MEM_SB;
                            3'b001:  mem = MEM_SH;
                            3'b010:  mem = MEM_SW;
                            default: bad = 1'b1;
                        endcase
                    end
                    riscv::OPC_BRANCH: begin
                        fmt = FMT_B;
                        alu = ALU_SUB;
                        br  = 1'b1;
                        if (funct3 == 3'b010 || funct3 == 3'b011) begin
                            bad = 1'b1;
                        end
                    end
                    riscv::OPC_LUI: begin
                        fmt = FMT_U;
                        alu = ALU_LUI;
                        we  = 1'b1;
                    end
                    riscv::OPC_AUIPC: begin
                        fmt = FMT_U;
                        alu = ALU_ADD;
                        upc = 1'b1;
                        we  = 1'b1;
                    end
                    riscv::OPC_JAL: begin
                        fmt = FMT_J;
                        alu = ALU_ADD;
                        upc = 1'b1;
                        jmp = 1'b1;
                        we  = 1'b1;
                    end
                    riscv::OPC_JALR: begin
                        fmt = FMT_I;
                        alu = ALU_ADD;
                        jmp = 1'b1;
                        we  = 1'b1;
                        if (funct3 != 3'b000) begin
                            bad = 1'b1;
                        end
                    end
                    default: bad = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        id_bus_o       = '0;
        id_bus_o.pc    = pc_i;
        id_bus_o.instr = instruction_i;
        id_bus_o.rd    = instruction_i[11:7];
        id_bus_o.rs1   = instruction_i[19:15];
        id_bus_o.rs2   = instruction_i[24:20];

        // an illegal word must not leak any partial decode into the pipeline
        if (bad) begin
            id_bus_o.format    = FMT_NOP;
            id_bus_o.alu_op    = ALU_NOP;
            id_bus_o.mem_op    = MEM_NOP;
            id_bus_o.rd_we     = 1'b0;
            id_bus_o.use_pc    = 1'b0;
            id_bus_o.is_branch = 1'b0;
            id_bus_o.is_jump   = 1'b0;
            id_bus_o.illegal   = 1'b1;
        end else begin
            id_bus_o.format    = fmt;
            id_bus_o.alu_op    = alu;
            id_bus_o.mem_op    = mem;
            id_bus_o.rd_we     = we;
            id_bus_o.use_pc    = upc;
            id_bus_o.is_branch = br;
            id_bus_o.is_jump   = jmp;
            id_bus_o.illegal   = 1'b0;
        end

        case (id_bus_o.format)
            FMT_I:   id_bus_o.imm = imm_i;
            FMT_S:   id_bus_o.imm = imm_s;
            FMT_B:   id_bus_o.imm = imm_b;
            FMT_U:   id_bus_o.imm = imm_u;
            FMT_J:   id_bus_o.imm = imm_j;
            default: id_bus_o.imm = 32'h0000_0000;
        endcase
    end

`ifdef ILLEGAL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_cnt_o <= 32'h0000_0000;
        end else if (id_bus_o.illegal) begin
            illegal_cnt_o <= illegal_cnt_o + 32'd1;
        end
    end
`else
    // clk/rst only serve the optional counter
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: tb/tb_rv32i_decoder.sv
// Self-checking bench for rv32i_decoder: directed vector table, random words against a
// field-level reference model, and the illegal counter sequence when ILLEGAL_CNT_EN is set.
module tb_rv32i_decoder;
    import core::*;

    logic        clk;
    logic        rst;
    logic [31:0] instruction_i;
    logic [31:0] pc_i;
    pipeline_bus_t id_bus_o;
`ifdef ILLEGAL_CNT_EN
    logic [31:0] illegal_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .instruction_i (instruction_i),
        .pc_i          (pc_i),
        .id_bus_o      (id_bus_o)
`ifdef ILLEGAL_CNT_EN
        ,
        .illegal_cnt_o (illegal_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [31:0]   instr;
        pipeline_bus_t exp;
    } vec_t;

    vec_t vecs[$];

    alu_op_t    alu_tbl   [8];
    mem_op_t    load_tbl  [8];
    mem_op_t    store_tbl [8];
    logic [6:0] opc_tbl   [11];

    function automatic pipeline_bus_t mk(input logic [31:0] pc, input logic [31:0] w,
                                         input format_t f, input int rd, input int rs1,
                                         input int rs2, input logic [31:0] imm,
                                         input alu_op_t a, input mem_op_t m, input bit we,
                                         input bit upc, input bit br, input bit jmp,
                                         input bit ill);
        pipeline_bus_t b;
        b.pc = pc; b.instr = w; b.format = f;
        b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2); b.imm = imm;
        b.alu_op = a; b.mem_op = m; b.rd_we = we; b.use_pc = upc;
        b.is_branch = br; b.is_jump = jmp; b.illegal = ill;
        return b;
    endfunction

    // Reference model: decodes from the ISA rules using lookup tables and plain arithmetic.
    function automatic pipeline_bus_t model(input logic [31:0] w, input logic [31:0] pc);
        pipeline_bus_t b;
        logic [6:0]  op;
        int          f3;
        int          f7;
        bit          ok;
        logic [31:0] sx;
        op = w[6:0];
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        sx = w[31] ? 32'hFFFF_FFFF : 32'h0;
        b = mk(pc, w, FMT_NOP, int'(w[11:7]), int'(w[19:15]), int'(w[24:20]), 32'h0,
               ALU_NOP, MEM_NOP, 0, 0, 0, 0, 0);
        if (w == 32'h0 || w == 32'h13) return b;
        ok = 1'b0;
        if (w[1:0] == 2'b11) begin
            case (op)
                7'h33: begin
                    ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                    b.format = FMT_R; b.rd_we = 1;
                    b.alu_op = (f7 == 0) ? alu_tbl[f3] : ((f3 == 0) ? ALU_SUB : ALU_SRA);
                end
                7'h13: begin
                    if (f3 == 1)      ok = (f7 == 0);
                    else if (f3 == 5) ok = (f7 == 0 || f7 == 32);
                    else              ok = 1;
                    b.format = FMT_I; b.rd_we = 1;
                    b.alu_op = (f3 == 5 && f7 == 32) ? ALU_SRA : alu_tbl[f3];
                end
                7'h03: begin
                    ok = (f3 <= 2) || f3 == 4 || f3 == 5;
                    b.format = FMT_I; b.rd_we = 1; b.alu_op = ALU_ADD; b.mem_op = load_tbl[f3];
                end
                7'h23: begin
                    ok = (f3 <= 2);
                    b.format = FMT_S; b.alu_op = ALU_ADD; b.mem_op = store_tbl[f3];
                end
                7'h63: begin
                    ok = (f3 != 2 && f3 != 3);
                    b.format = FMT_B; b.alu_op = ALU_SUB; b.is_branch = 1;
                end
                7'h37: begin ok = 1; b.format = FMT_U; b.alu_op = ALU_LUI; b.rd_we = 1; end
                7'h17: begin
                    ok = 1; b.format = FMT_U; b.alu_op = ALU_ADD; b.rd_we = 1; b.use_pc = 1;
                end
                7'h6F: begin
                    ok = 1; b.format = FMT_J; b.alu_op = ALU_ADD; b.rd_we = 1;
                    b.use_pc = 1; b.is_jump = 1;
                end
                7'h67: begin
                    ok = (f3 == 0);
                    b.format = FMT_I; b.alu_op = ALU_ADD; b.rd_we = 1; b.is_jump = 1;
                end
                default: ok = 0;
            endcase
        end
        if (!ok) begin
            b.format = FMT_NOP; b.alu_op = ALU_NOP; b.mem_op = MEM_NOP; b.rd_we = 0;
            b.use_pc = 0; b.is_branch = 0; b.is_jump = 0; b.illegal = 1;
        end
        case (b.format)
            FMT_I: b.imm = (sx << 12) | 32'(w[31:20]);
            FMT_S: b.imm = (sx << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
            FMT_B: b.imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
                           | (32'(w[11:8]) << 1);
            FMT_U: b.imm = w & 32'hFFFF_F000;
            FMT_J: b.imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
                           | (32'(w[30:21]) << 1);
            default: b.imm = 32'h0;
        endcase
        return b;
    endfunction

    task automatic check_bus(input string name, input pipeline_bus_t act, input pipeline_bus_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: instr=%h got %h required %h", name, act.instr, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [31:0] w, input format_t f,
                           input int rd, input int rs1, input int rs2, input logic [31:0] imm,
                           input alu_op_t a, input mem_op_t m, input bit we, input bit upc,
                           input bit br, input bit jmp, input bit ill);
        vec_t v;
        v.name  = name;
        v.instr = w;
        v.exp   = mk(32'h1000 + 32'(vecs.size() * 4), w, f, rd, rs1, rs2, imm, a, m,
                     we, upc, br, jmp, ill);
        vecs.push_back(v);
    endtask

`ifdef ILLEGAL_CNT_EN
    pipeline_bus_t ref_now;
    logic [31:0]   exp_cnt = 32'h0;
    always_comb ref_now = model(instruction_i, pc_i);
    always @(posedge clk or negedge rst) begin
        if (!rst) exp_cnt <= 32'h0;
        else if (ref_now.illegal) exp_cnt <= exp_cnt + 32'd1;
    end
`endif

    initial begin
        alu_tbl   = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        load_tbl  = '{MEM_LB, MEM_LH, MEM_LW, MEM_NOP, MEM_LBU, MEM_LHU, MEM_NOP, MEM_NOP};
        store_tbl = '{MEM_SB, MEM_SH, MEM_SW, MEM_NOP, MEM_NOP, MEM_NOP, MEM_NOP, MEM_NOP};
        opc_tbl   = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67,
                      7'h0F, 7'h73};

        add_vec("add",        32'h002081B3, FMT_R,   3,  1,  2, 32'h0,        ALU_ADD, MEM_NOP, 1, 0, 0, 0, 0);
        add_vec("lw",         32'hFFC12283, FMT_I,   5,  2, 28, 32'hFFFFFFFC, ALU_ADD, MEM_LW,  1, 0, 0, 0, 0);
        add_vec("sw",         32'h0060A423, FMT_S,   8,  1,  6, 32'h00000008, ALU_ADD, MEM_SW,  0, 0, 0, 0, 0);
        add_vec("beq",        32'hFE208CE3, FMT_B,  25,  1,  2, 32'hFFFFFFF8, ALU_SUB, MEM_NOP, 0, 0, 1, 0, 0);
        add_vec("lui",        32'h123453B7, FMT_U,   7,  8,  3, 32'h12345000, ALU_LUI, MEM_NOP, 1, 0, 0, 0, 0);
        add_vec("nop",        32'h00000013, FMT_NOP, 0,  0,  0, 32'h0,        ALU_NOP, MEM_NOP, 0, 0, 0, 0, 0);
        add_vec("zero",       32'h00000000, FMT_NOP, 0,  0,  0, 32'h0,        ALU_NOP, MEM_NOP, 0, 0, 0, 0, 0);
        add_vec("ones",       32'hFFFFFFFF, FMT_NOP,31, 31, 31, 32'h0,        ALU_NOP, MEM_NOP, 0, 0, 0, 0, 1);
        add_vec("add_x0",     32'h00208033, FMT_R,   0,  1,  2, 32'h0,        ALU_ADD, MEM_NOP, 1, 0, 0, 0, 0);
        add_vec("mul_bad_f7", 32'h02208133, FMT_NOP, 2,  1,  2, 32'h0,        ALU_NOP, MEM_NOP, 0, 0, 0, 0, 1);
        add_vec("srai",       32'h4030D093, FMT_I,   1,  1,  3, 32'h00000403, ALU_SRA, MEM_NOP, 1, 0, 0, 0, 0);
        add_vec("jal",        32'h008000EF, FMT_J,   1,  0,  8, 32'h00000008, ALU_ADD, MEM_NOP, 1, 1, 0, 1, 0);
        add_vec("auipc",      32'h00001117, FMT_U,   2,  0,  0, 32'h00001000, ALU_ADD, MEM_NOP, 1, 1, 0, 0, 0);
        add_vec("jalr_bad",   32'h00009067, FMT_NOP, 0,  1,  0, 32'h0,        ALU_NOP, MEM_NOP, 0, 0, 0, 0, 1);
        add_vec("br_bad_f3",  32'h0000A063, FMT_NOP, 0,  1,  0, 32'h0,        ALU_NOP, MEM_NOP, 0, 0, 0, 0, 1);
        add_vec("low_bits",   32'h00000092, FMT_NOP, 1,  0,  0, 32'h0,        ALU_NOP, MEM_NOP, 0, 0, 0, 0, 1);
        add_vec("slli_bad",   32'h02009093, FMT_NOP, 1,  1,  0, 32'h0,        ALU_NOP, MEM_NOP, 0, 0, 0, 0, 1);
        add_vec("fence",      32'h0000000F, FMT_NOP, 0,  0,  0, 32'h0,        ALU_NOP, MEM_NOP, 0, 0, 0, 0, 1);

        rst = 1'b1;
        instruction_i = 32'h0;
        pc_i = 32'h0;
        #1 rst = 1'b0;
        #2;
        check_bus("reset_bus", id_bus_o,
                  mk(32'h0, 32'h0, FMT_NOP, 0, 0, 0, 32'h0, ALU_NOP, MEM_NOP, 0, 0, 0, 0, 0));
`ifdef ILLEGAL_CNT_EN
        check_val("reset_cnt", illegal_cnt_o, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            instruction_i = vecs[i].instr;
            pc_i = vecs[i].exp.pc;
            #1;
            check_bus(vecs[i].name, id_bus_o, vecs[i].exp);
        end

`ifdef ILLEGAL_CNT_EN
        @(negedge clk);
        rst = 1'b0;
        instruction_i = 32'hFFFFFFFF;
        #1;
        check_val("cnt_clear", illegal_cnt_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("cnt_three", illegal_cnt_o, 32'd3);
        @(negedge clk);
        instruction_i = 32'h002081B3;
        @(posedge clk);
        #1;
        check_val("cnt_hold", illegal_cnt_o, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_val("cnt_async_rst", illegal_cnt_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
`endif

        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            int          k;
            @(negedge clk);
            w = $urandom;
            k = $urandom_range(0, 11);
            if (k < 11) w[6:0] = opc_tbl[k];
            if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            instruction_i = w;
            pc_i = $urandom;
            #1;
            check_bus("random", id_bus_o, model(w, pc_i));
`ifdef ILLEGAL_CNT_EN
            check_val("random_cnt", illegal_cnt_o, exp_cnt);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
